// File: rtl/button_debouncer_if.sv
// Pushbutton debouncer signal bundle: raw pin in, clean level and
// qualification status out.
interface button_debouncer_if;
  logic in;
  logic out;
  logic busy;

  modport master (output in, input out, input busy);
  modport slave  (input in, output out, output busy);
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus hold-time qualifier: out follows the button
// only after it has disagreed with out for STABLE_CYCLES consecutive clocks.
module button_debouncer #(
  parameter int   STABLE_CYCLES = 500000,
  parameter logic ACTIVE_LOW    = 1'b1,
  parameter int   CNT_W         = $clog2(STABLE_CYCLES) + 1
) (
  input logic            clk,
  input logic            reset,
  button_debouncer_if.slave bif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             p;
  logic             s1, s2;
  logic             out_q, out_nxt;
  logic [CNT_W-1:0] count, count_nxt;

  // Normalise polarity ahead of the synchroniser so everything downstream
  // sees 1 = pressed.
  assign p = bif.in ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= p;
      s2 <= s1;
    end
  end

  // Any cycle of agreement wipes the count: no partial credit for bounces.
  always_comb begin
    count_nxt = count;
    out_nxt   = out_q;
    if (s2 == out_q) begin
      count_nxt = '0;
    end else if (count == CNT_LAST) begin
      out_nxt   = s2;
      count_nxt = '0;
    end else begin
      count_nxt = count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      out_q <= 1'b0;
    end else begin
      count <= count_nxt;
      out_q <= out_nxt;
    end
  end

  assign bif.out  = out_q;
  assign bif.busy = (count != '0);

endmodule
